ram_fill_engine: RTL

Parametrised successor to the S-box RAM initializer. On a start request it writes a programmable address range of an on-chip RAM, one word per cycle, using one of four data patterns. Patterns are identity, constant, offset-ramp and descending. It sits ahead of the RC4 key-scheduling stage and uses the same start/finished handshake, adding stall back-pressure and range wrap-around.

---
 rtl/ram_fill_pkg.sv | 17 +
 rtl/ram_fill_datagen.sv | 31 +++
 rtl/ram_fill_engine.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ram_fill_pkg.sv
// Shared types for the RAM fill engine: fill pattern selector and FSM state encoding.
package ram_fill_pkg;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        CONST    = 2'd1,
        OFFSET   = 2'd2,
        DESCEND  = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } fill_state_e;

endpackage

// File: rtl/ram_fill_datagen.sv
// Combinational data-pattern generator: maps (mode, address, write index, seed) to a RAM word.
module ram_fill_datagen
    import ram_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  fill_mode_e         mode,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [ADDR_W:0]    k,
    input  logic [DATA_W-1:0]  fill_value,
    output logic [DATA_W-1:0]  data
);

    logic [ADDR_W-1:0] w_desc_addr;

    // 2^ADDR_W - 1 - A is the bitwise complement of A within ADDR_W bits.
    assign w_desc_addr = ~addr;

    always_comb begin
        data = '0;
        case (mode)
            IDENTITY: data = DATA_W'(addr);
            CONST:    data = fill_value;
            OFFSET:   data = fill_value + DATA_W'(k);
            DESCEND:  data = DATA_W'(w_desc_addr);
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/ram_fill_engine.sv
// Fills an inclusive, wrap-around address range of a RAM with a selectable pattern,
// one word per non-stalled cycle, using a start/finished 4-phase handshake.
module ram_fill_engine
    import ram_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              stall,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ram_in,
    output logic              finished,
    output logic              busy,
    output logic [1:0]        state
);

    fill_state_e       r_state, w_state_next;
    fill_mode_e        r_mode, w_mode_next;
    logic [DATA_W-1:0] r_fill, w_fill_next;
    logic [ADDR_W:0]   r_k, w_k_next;
    logic [ADDR_W:0]   r_kmax, w_kmax_next;
    logic              r_we, w_we_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_data, w_data_next;
    logic              r_finished, w_finished_next;
    logic              r_busy, w_busy_next;

    fill_mode_e        w_gen_mode;
    logic [ADDR_W-1:0] w_gen_addr;
    logic [ADDR_W:0]   w_gen_k;
    logic [DATA_W-1:0] w_gen_fill;
    logic [DATA_W-1:0] w_gen_data;
    logic              w_in_idle;

    // The generator sees the live config at accept, and the next write's operands in WRITE.
    assign w_in_idle  = (r_state == IDLE);
    assign w_gen_mode = w_in_idle ? fill_mode_e'(mode) : r_mode;
    assign w_gen_addr = w_in_idle ? base_addr : r_addr + ADDR_W'(1);
    assign w_gen_k    = w_in_idle ? '0 : r_k + (ADDR_W+1)'(1);
    assign w_gen_fill = w_in_idle ? fill_value : r_fill;

    ram_fill_datagen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_datagen (
        .mode       (w_gen_mode),
        .addr       (w_gen_addr),
        .k          (w_gen_k),
        .fill_value (w_gen_fill),
        .data       (w_gen_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_mode     <= IDENTITY;
            r_fill     <= '0;
            r_k        <= '0;
            r_kmax     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_finished <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mode     <= w_mode_next;
            r_fill     <= w_fill_next;
            r_k        <= w_k_next;
            r_kmax     <= w_kmax_next;
            r_we       <= w_we_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
            r_finished <= w_finished_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_mode_next     = r_mode;
        w_fill_next     = r_fill;
        w_k_next        = r_k;
        w_kmax_next     = r_kmax;
        w_addr_next     = r_addr;
        w_data_next     = r_data;
        w_we_next       = 1'b0;
        w_finished_next = 1'b0;
        w_busy_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mode_next  = fill_mode_e'(mode);
                    w_fill_next  = fill_value;
                    // Last index N-1 = (last - base) mod 2^ADDR_W, so N spans 1..2^ADDR_W.
                    w_kmax_next  = {1'b0, last_addr - base_addr};
                    w_k_next     = '0;
                    w_addr_next  = base_addr;
                    w_data_next  = w_gen_data;
                    w_we_next    = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_busy_next = 1'b1;
                if (!stall) begin
                    if (r_k == r_kmax) begin
                        w_state_next    = DONE;
                        w_finished_next = 1'b1;
                        w_busy_next     = 1'b0;
                    end else begin
                        w_k_next    = w_gen_k;
                        w_addr_next = w_gen_addr;
                        w_data_next = w_gen_data;
                        w_we_next   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    w_finished_next = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign write_enable = r_we;
    assign address      = r_addr;
    assign ram_in       = r_data;
    assign finished     = r_finished;
    assign busy         = r_busy;
    assign state        = r_state;

endmodule
